mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with burst locking. It drives a shared 4:1 data mux
// into a single-entry output register that supports ready/valid backpressure.
module mux4_rr_arbiter #(
   parameter int in_width  = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          req,
   input  logic [3:0]          lock,
   input  logic [in_width-1:0] data0,
   input  logic [in_width-1:0] data1,
   input  logic [in_width-1:0] data2,
   input  logic [in_width-1:0] data3,
   output logic [3:0]          gnt,
   output logic [1:0]          select,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [in_width-1:0] output0,
   output logic [1:0]          out_src
);

   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              r_state, w_state_next;
   logic [1:0]          r_owner, w_owner_next;
   logic [CW-1:0]       r_burst_cnt, w_burst_cnt_next;
   logic [1:0]          r_last;
   logic                r_out_valid;
   logic [in_width-1:0] r_output0;
   logic [1:0]          r_out_src;

   logic                w_slot_free;
   logic [3:0]          w_owner_oh;
   logic [3:0]          w_eligible;
   logic [1:0]          w_rr_winner;
   logic [1:0]          w_winner;
   logic                w_capture;
   logic [CW-1:0]       w_burst_inc;
   logic [in_width-1:0] w_data [4];

   assign w_data[0] = data0;
   assign w_data[1] = data1;
   assign w_data[2] = data2;
   assign w_data[3] = data3;

   assign w_slot_free = !r_out_valid || out_ready;
   assign w_owner_oh  = 4'(1) << r_owner;
   assign w_eligible  = (r_state == LOCKED) ? (req & w_owner_oh) : req;
   assign w_capture   = w_slot_free && (|w_eligible);
   assign w_burst_inc = r_burst_cnt + CW'(1);

   // Scan from the farthest candidate back to last+1 so the nearest set request wins.
   always_comb begin
      logic [1:0] idx;
      w_rr_winner = r_last;
      idx         = r_last;
      for (int k = 4; k >= 1; k--) begin
         idx = r_last + 2'(k);
         if (req[idx]) begin
            w_rr_winner = idx;
         end
      end
   end

   assign w_winner = (r_state == LOCKED) ? r_owner : w_rr_winner;
   assign select   = w_capture ? w_winner : r_last;
   assign gnt      = w_capture ? (4'(1) << w_winner) : 4'b0000;

   always_comb begin
      w_state_next     = r_state;
      w_owner_next     = r_owner;
      w_burst_cnt_next = r_burst_cnt;
      case (r_state)
         IDLE: begin
            if (w_capture && lock[w_winner]) begin
               w_state_next     = LOCKED;
               w_owner_next     = w_winner;
               w_burst_cnt_next = CW'(1);
            end
         end
         LOCKED: begin
            if (w_capture) begin
               if ((w_burst_inc < CW'(MAX_BURST)) && lock[r_owner]) begin
                  w_burst_cnt_next = w_burst_inc;
               end else begin
                  w_state_next     = IDLE;
                  w_burst_cnt_next = '0;
               end
            end else if (!req[r_owner] || !lock[r_owner]) begin
               w_state_next     = IDLE;
               w_burst_cnt_next = '0;
            end
            // Otherwise the owner is stalled by backpressure and keeps its burst count.
         end
         default: begin
            w_state_next     = IDLE;
            w_burst_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_owner     <= 2'd0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_owner     <= w_owner_next;
         r_burst_cnt <= w_burst_cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_output0   <= '0;
         r_out_src   <= 2'd0;
         r_last      <= 2'd3;
      end else if (w_capture) begin
         r_out_valid <= 1'b1;
         r_output0   <= w_data[select];
         r_out_src   <= w_winner;
         r_last      <= w_winner;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign output0   = r_output0;
   assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Cycle-by-cycle vector table for mux4_rr_arbiter; captured words go through a scoreboard
// queue and are checked when the downstream side takes them.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] lock;
   logic [7:0] data0, data1, data2, data3;
   logic [3:0] gnt;
   logic [1:0] select;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] output0;
   logic [1:0] out_src;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.in_width(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .data0     (data0),
      .data1     (data1),
      .data2     (data2),
      .data3     (data3),
      .gnt       (gnt),
      .select    (select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .output0   (output0),
      .out_src   (out_src)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] lock;
      logic       rdy;
      logic       chk;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       ov;
   } vec_t;

   vec_t        vecs[$];
   logic [9:0]  sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          row     = 0;

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd,
                      input logic ck, input logic [3:0] g, input logic [1:0] s, input logic v);
      vec_t e;
      e.rst_n = r; e.req = rq; e.lock = lk; e.rdy = rd;
      e.chk = ck; e.gnt = g; e.sel = s; e.ov = v;
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int b = 0; b < 4; b++) if (oh[b]) r = 2'(b);
      return r;
   endfunction

   initial begin
      logic [7:0] held;
      logic       prev_ov;
      logic [9:0] exp_word;

      //   rst  req      lock     rdy  chk  gnt      sel  ov_after
      add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 2'd0, 0);
      add(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd3, 0);
      add(1, 4'b1111, 4'b0000, 1, 1, 4'b0001, 2'd0, 1);
      add(1, 4'b1111, 4'b0000, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1111, 4'b0000, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b1111, 4'b0000, 1, 1, 4'b1000, 2'd3, 1);
      add(1, 4'b1111, 4'b0000, 1, 1, 4'b0001, 2'd0, 1);
      add(1, 4'b0101, 4'b0000, 0, 1, 4'b0000, 2'd0, 1);
      add(1, 4'b0101, 4'b0000, 0, 1, 4'b0000, 2'd0, 1);
      add(1, 4'b0101, 4'b0000, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 0);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 0);
      add(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 2'd0, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b1000, 2'd3, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0001, 2'd0, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1011, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b1001, 4'b0010, 1, 1, 4'b0000, 2'd1, 0);
      add(1, 4'b1001, 4'b0000, 1, 1, 4'b1000, 2'd3, 1);
      add(1, 4'b0100, 4'b0100, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0100, 4'b0100, 1, 1, 4'b0100, 2'd2, 1);
      add(0, 4'b0100, 4'b0100, 0, 0, 4'b0000, 2'd0, 0);
      add(1, 4'b1000, 4'b0000, 1, 1, 4'b1000, 2'd3, 1);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd3, 0);
      add(1, 4'b0100, 4'b0000, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0100, 4'b0000, 0, 1, 4'b0000, 2'd2, 1);
      add(1, 4'b0100, 4'b0000, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0100, 4'b0000, 0, 1, 4'b0000, 2'd2, 1);
      add(1, 4'b0100, 4'b0000, 1, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 0);
      add(1, 4'b0100, 4'b0000, 0, 1, 4'b0100, 2'd2, 1);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd2, 0);
      add(1, 4'b0010, 4'b0010, 0, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b0010, 4'b0010, 0, 1, 4'b0000, 2'd1, 1);
      add(1, 4'b0010, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b0010, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b0010, 4'b0010, 1, 1, 4'b0010, 2'd1, 1);
      add(1, 4'b0011, 4'b0010, 1, 1, 4'b0001, 2'd0, 1);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd0, 0);
      add(1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2'd0, 0);

      rst_n = 1'b0; req = '0; lock = '0; out_ready = 1'b1;
      data0 = '0; data1 = '0; data2 = '0; data3 = '0;
      prev_ov = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         row       = i;
         rst_n     = vecs[i].rst_n;
         req       = vecs[i].req;
         lock      = vecs[i].lock;
         out_ready = vecs[i].rdy;
         data0     = {2'd0, 6'(i)};
         data1     = {2'd1, 6'(i)};
         data2     = {2'd2, 6'(i)};
         data3     = {2'd3, 6'(i)};
         #3;
         if (vecs[i].chk) begin
            check("gnt", 32'(gnt), 32'(vecs[i].gnt));
            check("select", 32'(select), 32'(vecs[i].sel));
         end
         if (vecs[i].rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               exp_word = sb.pop_front();
               check("out_src", 32'(out_src), 32'(exp_word[9:8]));
               check("output0", 32'(output0), 32'(exp_word[7:0]));
            end
         end
         if (vecs[i].rst_n && vecs[i].gnt != 4'b0000) begin
            sb.push_back({oh_idx(vecs[i].gnt), oh_idx(vecs[i].gnt), 6'(i)});
         end
         held    = output0;
         prev_ov = out_valid;
         @(posedge clk); #1;
         check("out_valid", 32'(out_valid), 32'(vecs[i].ov));
         if (!vecs[i].rst_n) begin
            check("rst_output0", 32'(output0), 32'(0));
            check("rst_out_src", 32'(out_src), 32'(0));
            sb.delete();
         end else if (prev_ov && !vecs[i].rdy) begin
            check("stall_hold", 32'(output0), 32'(held));
         end
         $display("[TB] row %0d req=%b lock=%b rdy=%b exp_gnt=%b ov=%b src=%0d out=%02h",
                  i, vecs[i].req, vecs[i].lock, vecs[i].rdy, vecs[i].gnt, out_valid, out_src, output0);
      end

      row = vecs.size();
      check("sb_leftover", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
